// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one unified instruction/data memory port between the fetch (I) and
// load/store (D) requesters of the pipelined LEGv8 core. One access is in
// flight at a time. D requests win arbitration, but once D has been granted
// MAX_D_STREAK times in a row while a fetch waits, the fetch goes next.
// All state advances on the falling edge of CLK.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   When defined, a busy access that sees no MemReady for TIMEOUT cycles is
//   aborted. Done pulses with read data forced to zero and TimeoutErr pulses
//   in the same cycle. When undefined, the TimeoutErr port does not exist and
//   a busy access waits forever.
//
// Ports
//   CLK, Reset            clock (negedge active), async active-high reset
//   IReq, IAddr           fetch request / address (held until IDone)
//   IRData, IDone, IStall fetched instruction, completion pulse, stall
//   DReq, DRead, DWrite   data request and direction strobes (held until DDone)
//   DAddr, DWData         data address / store data
//   DRData, DDone, DStall load data (held between loads), completion, stall
//   MemAddr, MemRead,     memory address and strobes, driven from the
//   MemWrite, MemWData    request latched at grant
//   MemRData, MemReady    memory read data and completion
//   TimeoutErr            abort pulse (ARB_TIMEOUT_EN only)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int INST_W       = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              IReq,
    input  logic [ADDR_W-1:0] IAddr,
    output logic [INST_W-1:0] IRData,
    output logic              IDone,
    output logic              IStall,
    input  logic              DReq,
    input  logic              DRead,
    input  logic              DWrite,
    input  logic [ADDR_W-1:0] DAddr,
    input  logic [DATA_W-1:0] DWData,
    output logic [DATA_W-1:0] DRData,
    output logic              DDone,
    output logic              DStall,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [DATA_W-1:0] MemWData,
    input  logic [DATA_W-1:0] MemRData,
`ifdef ARB_TIMEOUT_EN
    input  logic              MemReady,
    output logic              TimeoutErr
`else
    input  logic              MemReady
`endif
);

    // state | meaning
    // IDLE  | no access in flight; arbitrates every edge (also during Done)
    // IBUSY | fetch access in flight, MemRead held high
    // DBUSY | load or store in flight, MemRead or MemWrite held high
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } state_t;

    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    state_t            state_q;
    logic [SW-1:0]     streak_q;
    logic [SW-1:0]     streak_d;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [INST_W-1:0] irdata_q;
    logic [DATA_W-1:0] drdata_q;
    logic              idone_q;
    logic              ddone_q;
    logic              valid_d;
    logic              d_grant;
    logic              i_grant;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] tmo_q;
    logic       terr_q;
    assign TimeoutErr = terr_q;
`endif

    always_comb begin
        valid_d  = DReq & (DRead | DWrite);
        // D wins unless the waiting fetch has already been passed over
        // MAX_D_STREAK times in a row.
        d_grant  = (state_q == IDLE) & valid_d & ~(IReq & (streak_q == STREAK_MAX));
        i_grant  = (state_q == IDLE) & ~d_grant & IReq;
        streak_d = streak_q;
        if (!IReq || i_grant) begin
            streak_d = '0;
        end else if (d_grant) begin
            streak_d = streak_q + SW'(1);
        end
    end

    always_ff @(negedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            irdata_q    <= '0;
            drdata_q    <= '0;
            idone_q     <= 1'b0;
            ddone_q     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            tmo_q       <= '0;
            terr_q      <= 1'b0;
`endif
        end else begin
            streak_q <= streak_d;
            idone_q  <= 1'b0;
            ddone_q  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            terr_q   <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (d_grant) begin
                        state_q     <= DBUSY;
                        mem_addr_q  <= DAddr;
                        mem_wdata_q <= DWData;
                        // both strobes set is treated as a store
                        mem_write_q <= DWrite;
                        mem_read_q  <= ~DWrite;
`ifdef ARB_TIMEOUT_EN
                        tmo_q       <= '0;
`endif
                    end else if (i_grant) begin
                        state_q     <= IBUSY;
                        mem_addr_q  <= IAddr;
                        mem_read_q  <= 1'b1;
                        mem_write_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
                        tmo_q       <= '0;
`endif
                    end
                end
                IBUSY, DBUSY: begin
                    if (MemReady) begin
                        state_q     <= IDLE;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        if (state_q == IBUSY) begin
                            idone_q  <= 1'b1;
                            irdata_q <= MemRData[INST_W-1:0];
                        end else begin
                            ddone_q <= 1'b1;
                            if (!mem_write_q) begin
                                drdata_q <= MemRData;
                            end
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (tmo_q == TMO_LAST) begin
                        state_q     <= IDLE;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        terr_q      <= 1'b1;
                        if (state_q == IBUSY) begin
                            idone_q  <= 1'b1;
                            irdata_q <= '0;
                        end else begin
                            ddone_q <= 1'b1;
                            if (!mem_write_q) begin
                                drdata_q <= '0;
                            end
                        end
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
`endif
                end
                default: begin
                    state_q     <= IDLE;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                end
            endcase
        end
    end

    assign MemAddr  = mem_addr_q;
    assign MemWData = mem_wdata_q;
    assign MemRead  = mem_read_q;
    assign MemWrite = mem_write_q;
    assign IRData   = irdata_q;
    assign DRData   = drdata_q;
    assign IDone    = idone_q;
    assign DDone    = ddone_q;
    assign IStall   = IReq & ~idone_q;
    assign DStall   = DReq & ~ddone_q;

endmodule
